// File: rtl/osc_rst_sequencer.sv
// Reset sequencer: init_done sync, staged fabric/core reset release,
// ready flag and free-running timebase tick.
module osc_rst_sequencer #(
    parameter int HOLD_CYCLES = 256,
    parameter int STAGE_GAP   = 16,
    parameter int TICK_DIV    = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       soft_rst_req,
    output logic       rst_fabric,
    output logic       rst_core,
    output logic       ready,
    output logic       tick,
    output logic [2:0] state
);

    localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
    localparam int TW   = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        HOLD      = 3'd1,
        REL_FAB   = 3'd2,
        REL_CORE  = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          sync1;
    logic          init_s;
    logic [TW-1:0] tcnt;
    logic          fab_nxt;
    logic          core_nxt;
    logic          rdy_nxt;

    // Two-flop synchroniser for the asynchronous init_done level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            init_s <= 1'b0;
        end else begin
            sync1  <= init_done;
            init_s <= sync1;
        end
    end

    // Next state and stage counter; aborts take priority over sequencing
    always_comb begin
        nxt     = cur;
        cnt_nxt = cnt;
        if (cur != WAIT_INIT && !init_s) begin
            nxt     = WAIT_INIT;
            cnt_nxt = '0;
        end else if (cur != WAIT_INIT && soft_rst_req) begin
            nxt     = HOLD;
            cnt_nxt = '0;
        end else begin
            case (cur)
                WAIT_INIT: begin
                    cnt_nxt = '0;
                    if (init_s) nxt = HOLD;
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        nxt     = REL_FAB;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                REL_FAB: begin
                    if (cnt == GAP_LAST) begin
                        nxt     = REL_CORE;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                REL_CORE: begin
                    if (cnt == GAP_LAST) begin
                        nxt     = RUN;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                RUN: begin
                    cnt_nxt = '0;
                end
                default: begin
                    nxt     = WAIT_INIT;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    // Output decode from next state so outputs move with the state register
    always_comb begin
        fab_nxt  = (nxt == WAIT_INIT) || (nxt == HOLD);
        core_nxt = fab_nxt || (nxt == REL_FAB);
        rdy_nxt  = (nxt == RUN);
    end

    // State, counter and registered reset outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= WAIT_INIT;
            cnt        <= '0;
            rst_fabric <= 1'b1;
            rst_core   <= 1'b1;
            ready      <= 1'b0;
        end else begin
            cur        <= nxt;
            cnt        <= cnt_nxt;
            rst_fabric <= fab_nxt;
            rst_core   <= core_nxt;
            ready      <= rdy_nxt;
        end
    end

    // Free-running timebase; tick lands TICK_DIV edges after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (tcnt == TICK_LAST);
            if (tcnt == TICK_LAST) tcnt <= '0;
            else tcnt <= tcnt + TW'(1);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_osc_rst_sequencer.sv
// Directed bench for osc_rst_sequencer with HOLD=8, GAP=4, TICK=5.
// Table rows for power-up, hand sequences for aborts and priority.
module tb_osc_rst_sequencer;

    logic       clk;
    logic       rst;
    logic       init_done;
    logic       soft_rst_req;
    logic       rst_fabric;
    logic       rst_core;
    logic       ready;
    logic       tick;
    logic [2:0] state;

    int n_tests;
    int n_fail;
    int since;

    typedef struct {
        logic       r;
        logic       i;
        logic       s;
        logic       fab;
        logic       core;
        logic       rdy;
        logic [2:0] st;
        logic       tk;
    } vec_t;

    vec_t tbl[$];

    osc_rst_sequencer #(
        .HOLD_CYCLES(8),
        .STAGE_GAP  (4),
        .TICK_DIV   (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_done   (init_done),
        .soft_rst_req(soft_rst_req),
        .rst_fabric  (rst_fabric),
        .rst_core    (rst_core),
        .ready       (ready),
        .tick        (tick),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic i, input logic s);
        @(negedge clk);
        rst          = r;
        init_done    = i;
        soft_rst_req = s;
        @(posedge clk);
        #1;
        if (r) since = 0;
        else since++;
    endtask

    task automatic chk_tick();
        chk("tick_model", int'(tick), int'(since > 0 && since % 5 == 0));
    endtask

    task automatic chk_out(input string tag, input logic f, input logic c,
                           input logic y, input logic [2:0] st);
        chk({tag, "_fab"}, int'(rst_fabric), int'(f));
        chk({tag, "_core"}, int'(rst_core), int'(c));
        chk({tag, "_rdy"}, int'(ready), int'(y));
        chk({tag, "_state"}, int'(state), int'(st));
    endtask

    function automatic void add(input logic r, input logic i, input logic s,
                                input logic f, input logic c, input logic y,
                                input logic [2:0] st, input logic tk);
        vec_t v;
        v.r = r; v.i = i; v.s = s;
        v.fab = f; v.core = c; v.rdy = y; v.st = st; v.tk = tk;
        tbl.push_back(v);
    endfunction

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        since        = 0;
        rst          = 1'b1;
        init_done    = 1'b0;
        soft_rst_req = 1'b0;

        // rows 0-2 reset; init_done high at row 3 (E=3), soft ignored there
        add(1, 0, 0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 0, 0);
        add(0, 1, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 1, 1);
        add(0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 1, 1);
        add(0, 1, 0, 0, 1, 0, 2, 0);
        add(0, 1, 0, 0, 1, 0, 2, 0);
        add(0, 1, 0, 0, 1, 0, 2, 0);
        add(0, 1, 0, 0, 1, 0, 2, 0);
        add(0, 1, 0, 0, 0, 0, 3, 1);
        add(0, 1, 0, 0, 0, 0, 3, 0);
        add(0, 1, 0, 0, 0, 0, 3, 0);
        add(0, 1, 0, 0, 0, 0, 3, 0);
        add(0, 1, 0, 0, 0, 1, 4, 0);
        add(0, 1, 0, 0, 0, 1, 4, 1);

        foreach (tbl[k]) begin
            cyc(tbl[k].r, tbl[k].i, tbl[k].s);
            chk($sformatf("row%0d_fab", k), int'(rst_fabric), int'(tbl[k].fab));
            chk($sformatf("row%0d_core", k), int'(rst_core), int'(tbl[k].core));
            chk($sformatf("row%0d_rdy", k), int'(ready), int'(tbl[k].rdy));
            chk($sformatf("row%0d_state", k), int'(state), int'(tbl[k].st));
            chk($sformatf("row%0d_tick", k), int'(tick), int'(tbl[k].tk));
        end

        // soft reset in RUN: immediate reassert, ready back 16 edges later
        cyc(0, 1, 1);
        chk_tick();
        chk_out("soft", 1, 1, 0, 1);
        for (int k = 0; k < 15; k++) begin
            cyc(0, 1, 0);
            chk_tick();
            chk("soft_wait_rdy", int'(ready), 0);
        end
        cyc(0, 1, 0);
        chk_tick();
        chk_out("soft_done", 0, 0, 1, 4);

        // init glitch mid-HOLD: back to WAIT_INIT, full HOLD restarts
        cyc(0, 1, 1);
        chk_tick();
        chk_out("gl_hold", 1, 1, 0, 1);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk_tick();
        cyc(0, 1, 0);
        chk_tick();
        chk_out("gl_still", 1, 1, 0, 1);
        cyc(0, 1, 0);
        chk_tick();
        chk_out("gl_wait", 1, 1, 0, 0);
        cyc(0, 1, 0);
        chk_tick();
        chk_out("gl_rehold", 1, 1, 0, 1);
        for (int k = 0; k < 7; k++) begin
            cyc(0, 1, 0);
            chk_tick();
            chk_out("gl_holding", 1, 1, 0, 1);
        end
        cyc(0, 1, 0);
        chk_tick();
        chk_out("gl_relfab", 0, 1, 0, 2);

        // init_s drop together with soft request in REL_CORE
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0);
            chk_tick();
        end
        chk_out("pr_relcore", 0, 0, 0, 3);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk_tick();
        chk_out("pr_pre", 0, 0, 0, 3);
        cyc(0, 0, 1);
        chk_tick();
        chk_out("pr_wait", 1, 1, 0, 0);

        // rst asserted during REL_FAB; tick phase restarts from it
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        chk_tick();
        chk_out("rm_hold", 1, 1, 0, 1);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 0);
            chk_tick();
        end
        chk_out("rm_relfab", 0, 1, 0, 2);
        cyc(1, 1, 0);
        chk_out("rm_rst", 1, 1, 0, 0);
        chk("rm_tick", int'(tick), 0);
        for (int k = 0; k < 12; k++) begin
            cyc(0, 1, 0);
            chk_tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
